pixel_writeback: RTL and testbench
==================================

# pixel_writeback

Collects 32-bit pixel results from the ray-tracing core over a valid/ready stream and packs them into batches of BATCH words. Each full or final partial batch is handed to the SDRAM Avalon write stage through its start/end handshake, targeting consecutive framebuffer addresses. The block sits directly upstream of the SDRAM write stage and is the only driver of that stage's write-side inputs.

## Interface
- BATCH, 4, number of 32-bit words per SDRAM write transaction; must equal the write stage's MAX_NWRITE; range 1..64.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- frame_base  in  32  framebuffer byte address; sampled with frame_start; must be 4-byte aligned.
- frame_npixels  in  30  number of pixels in the frame; sampled with frame_start.
- pix_valid  in  1  pixel word available.
- pix_data  in  32  pixel word.
- pix_ready  out  1  block accepts pix_data this cycle when pix_valid is also high.
- sdr_baseaddr  out  32  byte address of word 0 of the current batch.
- sdr_nelems  out  30  number of 32-bit words in the current batch (1..BATCH).
- sdr_writedata  out  32*BATCH  batch data; word i is at bits [32i +: 32] and is written to sdr_baseaddr + 4i.
- sdr_writestart  out  1  one-cycle pulse that starts a batch write.
- sdr_writeend  in  1  one-cycle pulse from the write stage when the batch is complete.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the last batch of the frame has completed.

## Operation
- States:
  - IDLE: wait for a frame.
  - FILL: accept pixels into the batch buffer.
  - START: drive the write request.
  - WAIT: wait for the write stage to finish.
  - DONE: signal frame completion.
- IDLE:
  - On frame_start, latch frame_base into addr_r and frame_npixels into remain_r, clear fill_cnt, clear the buffer, and go to FILL.
  - If frame_npixels == 0, go to DONE instead.
- FILL:
  - pix_ready = (fill_cnt < BATCH) && (fill_cnt < remain_r).
  - On each accept (pix_valid && pix_ready), store pix_data in buffer word fill_cnt and increment fill_cnt.
  - Leave for START when the batch is full, i.e. fill_cnt == BATCH or fill_cnt == remain_r. The comparison uses the updated count, so the transition happens on the cycle after the last accept.
- START:
  - Assert sdr_writestart for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold sdr_baseaddr, sdr_nelems and sdr_writedata stable until sdr_writeend is seen.
  - On sdr_writeend:
    - addr_r += 4*BATCH (modulo 2^32).
    - remain_r -= fill_cnt.
    - Clear fill_cnt and the buffer.
  - Next state: DONE if remain_r - fill_cnt == 0, otherwise FILL.
- DONE:
  - Assert frame_done for one cycle, then go to IDLE.
- Output driving:
  - sdr_baseaddr = addr_r.
  - sdr_nelems = fill_cnt, zero-extended.
  - sdr_writedata = buffer; unfilled words of a partial batch read 0.
- Boundary rules:
  - frame_start outside IDLE is ignored.
  - sdr_writeend outside WAIT is ignored.
  - pix_valid outside FILL is not accepted, since pix_ready is 0 there.
  - Single buffer: no pixels are accepted during START or WAIT.

## Timing
- Reset values:
  - State IDLE.
  - pix_ready, sdr_writestart, busy and frame_done all 0.
  - sdr_baseaddr 0, sdr_nelems 0, sdr_writedata 0.
  - All counters 0.
- Reset mid-frame abandons the frame immediately. No frame_done is produced, and the write stage shares the same reset.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output except pix_ready, which depends only on state and counters.
- The cycle after frame_start has busy=1, and pix_ready=1 if frame_npixels > 0.
- sdr_writestart is asserted one cycle after the accept that completes the batch.
- sdr_writestart is never high for two consecutive cycles. This is required because the write stage restarts if start is still high when it returns to its idle state.
- Next pix_ready after sdr_writeend: one cycle later.
- frame_done after the final sdr_writeend: one cycle later.
- frame_npixels == 0: frame_done one cycle after frame_start, with no sdr_writestart.

## Test plan
- Full frame:
  - Stimulus: BATCH=4, frame_base=0x1000, npixels=8, continuous pix_valid with data 1..8; writeend 5 cycles after each start.
  - Required response: two starts; batch 1 has baseaddr 0x1000, nelems 4, writedata {4,3,2,1}; batch 2 has baseaddr 0x1010; frame_done once.
- Partial batch:
  - Stimulus: npixels=6.
  - Required response: second batch has nelems 2, words 2..3 = 0, baseaddr base+0x10.
- Backpressure and bubbles:
  - Stimulus: random pix_valid gaps; hold writeend off for 50 cycles.
  - Required response: pix_ready=0 throughout WAIT; sdr_writedata and sdr_baseaddr stable; no data lost or duplicated.
- Zero-length frame and ignored start:
  - Stimulus: npixels=0; also a frame_start pulsed during WAIT.
  - Required response: for npixels=0, frame_done one cycle after frame_start with no writestart; the frame_start during WAIT changes nothing.
- Reset mid-WAIT:
  - Stimulus: assert reset during WAIT.
  - Required response: next cycle all outputs at reset values; a new frame then runs correctly from its own frame_base.
- Address wrap:
  - Stimulus: frame_base=0xFFFFFFF0, npixels=8.
  - Required response: second batch baseaddr 0x00000000.

Source files
------------

// File: rtl/pixel_writeback.sv
// Packs streamed 32-bit pixels into BATCH-word bursts and hands each burst to the
// SDRAM write stage at consecutive framebuffer addresses.
module pixel_writeback #(
    parameter int BATCH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [31:0]           frame_base,
    input  logic [29:0]           frame_npixels,
    input  logic                  pix_valid,
    input  logic [31:0]           pix_data,
    output logic                  pix_ready,
    output logic [31:0]           sdr_baseaddr,
    output logic [29:0]           sdr_nelems,
    output logic [32*BATCH-1:0]   sdr_writedata,
    output logic                  sdr_writestart,
    input  logic                  sdr_writeend,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = $clog2(BATCH + 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        START,
        WAIT,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [31:0]   addr_r;
    logic [29:0]   remain_r;
    logic [CW-1:0] fill_cnt, fill_next;
    logic [31:0]   buf_r [BATCH];
    logic          accept;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // The batch closes on the updated count so START follows the last accept directly.
    always_comb begin
        state_next = state;
        pix_ready  = (state == FILL) && (fill_cnt < CW'(BATCH)) && (30'(fill_cnt) < remain_r);
        accept     = pix_valid && pix_ready;
        fill_next  = accept ? fill_cnt + CW'(1) : fill_cnt;
        case (state)
            IDLE: begin
                if (frame_start)
                    state_next = (frame_npixels == 30'd0) ? DONE : FILL;
            end
            FILL: begin
                if (fill_next == CW'(BATCH) || 30'(fill_next) == remain_r)
                    state_next = START;
            end
            START: state_next = WAIT;
            WAIT: begin
                if (sdr_writeend)
                    state_next = (remain_r == 30'(fill_cnt)) ? DONE : FILL;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r   <= '0;
            remain_r <= '0;
            fill_cnt <= '0;
            for (int i = 0; i < BATCH; i++) buf_r[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        addr_r   <= frame_base;
                        remain_r <= frame_npixels;
                        fill_cnt <= '0;
                        for (int i = 0; i < BATCH; i++) buf_r[i] <= '0;
                    end
                end
                FILL: begin
                    fill_cnt <= fill_next;
                    for (int i = 0; i < BATCH; i++)
                        if (accept && fill_cnt == CW'(i)) buf_r[i] <= pix_data;
                end
                WAIT: begin
                    if (sdr_writeend) begin
                        addr_r   <= addr_r + 32'(4 * BATCH);
                        remain_r <= remain_r - 30'(fill_cnt);
                        fill_cnt <= '0;
                        for (int i = 0; i < BATCH; i++) buf_r[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < BATCH; i++) sdr_writedata[32*i +: 32] = buf_r[i];
    end

    assign sdr_baseaddr   = addr_r;
    assign sdr_nelems     = 30'(fill_cnt);
    assign sdr_writestart = (state == START);
    assign busy           = (state != IDLE);
    assign frame_done     = (state == DONE);

endmodule

// File: tb/tb_pixel_writeback.sv
// Scoreboard bench for pixel_writeback: expected batches are queued per frame and
// popped as the DUT raises sdr_writestart; the bench also plays the SDRAM write stage.
module tb_pixel_writeback;

    localparam int BATCH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                frame_start;
    logic [31:0]         frame_base;
    logic [29:0]         frame_npixels;
    logic                pix_valid;
    logic [31:0]         pix_data;
    logic                pix_ready;
    logic [31:0]         sdr_baseaddr;
    logic [29:0]         sdr_nelems;
    logic [32*BATCH-1:0] sdr_writedata;
    logic                sdr_writestart;
    logic                sdr_writeend;
    logic                busy;
    logic                frame_done;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0]         base;
        logic [29:0]         nelems;
        logic [32*BATCH-1:0] data;
    } batch_t;

    batch_t exp_q[$];

    pixel_writeback #(.BATCH(BATCH)) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .frame_base     (frame_base),
        .frame_npixels  (frame_npixels),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_ready      (pix_ready),
        .sdr_baseaddr   (sdr_baseaddr),
        .sdr_nelems     (sdr_nelems),
        .sdr_writedata  (sdr_writedata),
        .sdr_writestart (sdr_writestart),
        .sdr_writeend   (sdr_writeend),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    // Runs one frame end to end; all sampling and driving happens on the falling edge.
    task automatic run_frame(input logic [31:0] base, input int n, input logic [31:0] first_val,
                             input int gap_pct, input int we_delay, input bit inject_start);
        logic [31:0]         pix[$];
        batch_t              b;
        logic [31:0]         snap_addr;
        logic [32*BATCH-1:0] snap_data;
        int idx = 0, wait_cnt = 0, cycles = 0, cnt;
        bit acc = 0, expect_start = 0, in_write = 0, ended = 0, prev_start = 0, finished = 0;

        exp_q.delete();
        for (int i = 0; i < n; i++) pix.push_back(first_val + 32'(i));
        for (int k = 0; k * BATCH < n; k++) begin
            cnt    = (n - k * BATCH < BATCH) ? n - k * BATCH : BATCH;
            b.base = base + 32'(16 * k);
            b.data = '0;
            for (int j = 0; j < cnt; j++) b.data[32*j +: 32] = pix[k*BATCH + j];
            b.nelems = 30'(cnt);
            exp_q.push_back(b);
        end

        @(negedge clk);
        frame_start   = 1'b1;
        frame_base    = base;
        frame_npixels = 30'(n);
        @(negedge clk);
        frame_start = 1'b0;
        tests_run++;
        if ({busy, pix_ready} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL frame_entry: busy,pix_ready got %b, expected 11", {busy, pix_ready});
        end

        while (!finished) begin
            frame_start  = 1'b0;
            sdr_writeend = 1'b0;
            if (acc) idx++;
            if (expect_start) begin
                expect_start = 0;
                tests_run++;
                if (sdr_writestart !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL start_latency: writestart got %b, expected 1", sdr_writestart);
                end
            end
            if (ended) begin
                ended = 0;
                tests_run++;
                if (exp_q.size() > 0 && pix_ready !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL refill_ready: pix_ready got %b, expected 1", pix_ready);
                end else if (exp_q.size() == 0 && frame_done !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL done_latency: frame_done got %b, expected 1", frame_done);
                end
            end
            if (sdr_writestart) begin
                tests_run++;
                if (prev_start) begin
                    tests_failed++;
                    $display("[TB] FAIL double_start: writestart high two cycles, expected one");
                end
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL extra_batch: got writestart at %h, expected none", sdr_baseaddr);
                end else begin
                    b = exp_q.pop_front();
                    if (sdr_baseaddr !== b.base || sdr_nelems !== b.nelems || sdr_writedata !== b.data) begin
                        tests_failed++;
                        $display("[TB] FAIL batch: got addr %h n %0d data %h, expected addr %h n %0d data %h",
                                 sdr_baseaddr, sdr_nelems, sdr_writedata, b.base, b.nelems, b.data);
                    end
                end
                snap_addr = sdr_baseaddr;
                snap_data = sdr_writedata;
                in_write  = 1;
                wait_cnt  = we_delay;
            end else if (in_write) begin
                tests_run++;
                if (pix_ready !== 1'b0 || sdr_baseaddr !== snap_addr || sdr_writedata !== snap_data) begin
                    tests_failed++;
                    $display("[TB] FAIL wait_hold: ready %b addr %h data %h, expected ready 0 addr %h data %h",
                             pix_ready, sdr_baseaddr, sdr_writedata, snap_addr, snap_data);
                end
                wait_cnt--;
                if (inject_start && wait_cnt == we_delay - 2) begin
                    frame_start   = 1'b1;
                    frame_base    = 32'hDEAD_0000;
                    frame_npixels = 30'd99;
                end
                if (wait_cnt == 0) begin
                    sdr_writeend = 1'b1;
                    in_write     = 0;
                    ended        = 1;
                end
            end
            prev_start = sdr_writestart;
            if (frame_done) finished = 1;
            if (!finished && idx < n && $urandom_range(99) >= gap_pct) begin
                pix_valid = 1'b1;
                pix_data  = pix[idx];
            end else begin
                pix_valid = 1'b0;
                pix_data  = $urandom;
            end
            acc = pix_valid && pix_ready;
            if (acc && ((idx + 1) % BATCH == 0 || idx + 1 == n)) expect_start = 1;
            cycles++;
            if (cycles > 3000) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL timeout: frame_done not seen in 3000 cycles, expected it");
                finished = 1;
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || exp_q.size() != 0 || idx != n) begin
            tests_failed++;
            $display("[TB] FAIL frame_end: busy %b done %b left %0d accepted %0d, expected 0 0 0 %0d",
                     busy, frame_done, exp_q.size(), idx, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({pix_ready, sdr_writestart, busy, frame_done} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b, expected 0000", {pix_ready, sdr_writestart, busy, frame_done});
        end
        tests_run++;
        if (sdr_baseaddr !== 32'h0 || sdr_nelems !== 30'h0 || sdr_writedata !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: addr %h n %0d data %h, expected all zero",
                     sdr_baseaddr, sdr_nelems, sdr_writedata);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_frame();
        run_frame(32'h0000_1000, 8, 32'd1, 0, 5, 0);
    endtask

    task automatic test_partial_batch();
        run_frame(32'h0000_2000, 6, 32'h100, 0, 5, 0);
    endtask

    task automatic test_backpressure();
        run_frame(32'h0000_4000, 19, 32'hA000, 40, 50, 0);
    endtask

    task automatic test_zero_and_ignored_start();
        @(negedge clk);
        frame_start   = 1'b1;
        frame_base    = 32'h0000_7000;
        frame_npixels = 30'd0;
        @(negedge clk);
        frame_start = 1'b0;
        tests_run++;
        if ({frame_done, busy, sdr_writestart, pix_ready} !== 4'b1100) begin
            tests_failed++;
            $display("[TB] FAIL zero_frame: done,busy,start,ready got %b, expected 1100",
                     {frame_done, busy, sdr_writestart, pix_ready});
        end
        @(negedge clk);
        tests_run++;
        if ({frame_done, busy, sdr_writestart} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL zero_frame_idle: done,busy,start got %b, expected 000",
                     {frame_done, busy, sdr_writestart});
        end
        run_frame(32'h0000_6000, 8, 32'h600, 20, 6, 1);
    endtask

    task automatic test_reset_mid_wait();
        int guard = 0;
        logic [31:0] next_val = 32'h900;
        @(negedge clk);
        frame_start   = 1'b1;
        frame_base    = 32'h0000_3000;
        frame_npixels = 30'd4;
        @(negedge clk);
        frame_start = 1'b0;
        while (!sdr_writestart && guard < 50) begin
            pix_valid = 1'b1;
            pix_data  = next_val;
            if (pix_ready) next_val++;
            guard++;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        tests_run++;
        if (sdr_writestart !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_setup: writestart got %b, expected 1", sdr_writestart);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({pix_ready, sdr_writestart, busy, frame_done} !== 4'b0000 ||
            sdr_baseaddr !== 32'h0 || sdr_nelems !== 30'h0 || sdr_writedata !== '0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: flags %b addr %h n %0d data %h, expected all zero",
                     {pix_ready, sdr_writestart, busy, frame_done}, sdr_baseaddr, sdr_nelems, sdr_writedata);
        end
        reset = 1'b0;
        run_frame(32'h0000_5000, 5, 32'h500, 10, 4, 0);
    endtask

    task automatic test_addr_wrap();
        run_frame(32'hFFFF_FFF0, 8, 32'h77, 0, 3, 0);
    endtask

    initial begin
        reset         = 1'b1;
        frame_start   = 1'b0;
        frame_base    = '0;
        frame_npixels = '0;
        pix_valid     = 1'b0;
        pix_data      = '0;
        sdr_writeend  = 1'b0;
        test_reset();
        test_full_frame();
        test_partial_batch();
        test_backpressure();
        test_zero_and_ignored_start();
        test_reset_mid_wait();
        test_addr_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
